cpu_clock_ctrl: RTL and testbench

- Sits directly downstream of the CPU clock divider.
- Converts the divider's slow square-wave `tick_in` into single-cycle `cpu_en` strobes in the fast `clk` domain.
- Gates the strobes with run/halt/single-step control from two debounced board pushbuttons and the CPU's HLT signal.
- The BatPU core advances one instruction per `cpu_en`; it never uses the slow clock as a clock.

---
 rtl/cpu_clock_ctrl.sv | 123 ++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_ctrl.sv
// Turns the slow divider level into single-cycle cpu_en strobes in the clk domain,
// gated by run/halt/single-step control from debounced pushbuttons and CPU HLT.
module cpu_clock_ctrl #(
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int COUNT_W         = 32
) (
   input  logic               clk,
   input  logic               rst_btn,
   input  logic               tick_in,
   input  logic               run_btn,
   input  logic               step_btn,
   input  logic               cpu_halt,
   output logic               cpu_en,
   output logic               running,
   output logic [COUNT_W-1:0] cycle_count,
   output logic [1:0]         state_dbg
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      HALT = 2'd0,
      STEP = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t           state;
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       deb;
   logic [1:0]       press;
   logic [CNT_W-1:0] cnt [2];
   logic             tick_prev;
   logic             tick_edge;
   logic             run_press;
   logic             step_press;

   // Bit 0 is the run button, bit 1 the step button; both idle high.
   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) begin
         sync1 <= 2'b11;
         sync2 <= 2'b11;
         deb   <= 2'b11;
         press <= 2'b00;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         sync1 <= {step_btn, run_btn};
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               cnt[i]   <= '0;
               deb[i]   <= sync2[i];
               press[i] <= ~sync2[i];
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign run_press  = press[0];
   assign step_press = press[1];

   // Reset to 1 so a high tick_in at reset release is not seen as a rising edge.
   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) tick_prev <= 1'b1;
      else          tick_prev <= tick_in;
   end

   assign tick_edge = tick_in & ~tick_prev;

   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) begin
         state       <= HALT;
         cpu_en      <= 1'b0;
         running     <= 1'b0;
         cycle_count <= '0;
      end else begin
         cpu_en <= 1'b0;
         case (state)
            HALT: begin
               if (run_press) begin
                  state   <= RUN;
                  running <= 1'b1;
               end else if (step_press) begin
                  state <= STEP;
               end
            end
            STEP: begin
               if (run_press) begin
                  state   <= RUN;
                  running <= 1'b1;
               end else if (tick_edge) begin
                  state       <= HALT;
                  cpu_en      <= 1'b1;
                  cycle_count <= cycle_count + COUNT_W'(1);
               end
            end
            RUN: begin
               // A halt request on the same cycle as a tick edge suppresses that strobe.
               if (cpu_halt || run_press) begin
                  state   <= HALT;
                  running <= 1'b0;
               end else if (tick_edge) begin
                  cpu_en      <= 1'b1;
                  cycle_count <= cycle_count + COUNT_W'(1);
               end
            end
            default: begin
               state   <= HALT;
               running <= 1'b0;
            end
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Bench for cpu_clock_ctrl: directed scenarios plus random button/halt traffic,
// every cycle compared with a window-based reference model.
module tb_cpu_clock_ctrl;

   localparam int DEB = 4;
   localparam int CW  = 32;
   localparam int HW  = DEB + 2;
   localparam int M_HALT = 0;
   localparam int M_STEP = 1;
   localparam int M_RUN  = 2;

   logic          clk      = 1'b0;
   logic          rst_btn  = 1'b1;
   logic          tick_in  = 1'b1;
   logic          run_btn  = 1'b1;
   logic          step_btn = 1'b1;
   logic          cpu_halt = 1'b0;
   logic          cpu_en;
   logic          running;
   logic [CW-1:0] cycle_count;
   logic [1:0]    state_dbg;

   int n_checks = 0;
   int n_pass   = 0;

   cpu_clock_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .COUNT_W        (CW)
   ) dut (
      .clk        (clk),
      .rst_btn    (rst_btn),
      .tick_in    (tick_in),
      .run_btn    (run_btn),
      .step_btn   (step_btn),
      .cpu_halt   (cpu_halt),
      .cpu_en     (cpu_en),
      .running    (running),
      .cycle_count(cycle_count),
      .state_dbg  (state_dbg)
   );

   // ---------------- clock / reset / tick ----------------
   always #5 clk = ~clk;

   int tick_ph   = 0;
   bit tick_hold = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (tick_hold) begin
            tick_in = 1'b0;
            tick_ph = 9;
         end else begin
            tick_ph = (tick_ph + 1) % 10;
            tick_in = (tick_ph < 5);
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // ---------------- reference model ----------------
   int            m_mode       = M_HALT;
   bit            m_en         = 1'b0;
   logic [CW-1:0] m_count      = '0;
   bit            m_tick_prev  = 1'b1;
   bit            m_te;
   bit            m_run_deb    = 1'b1;
   bit            m_step_deb   = 1'b1;
   bit            m_run_press  = 1'b0;
   bit            m_step_press = 1'b0;
   bit [HW-1:0]   run_hist     = '1;
   bit [HW-1:0]   step_hist    = '1;

   // True when the DEB samples that have cleared the synchroniser all equal lvl.
   function automatic bit settled(input bit [HW-1:0] h, input bit lvl);
      for (int i = 2; i < HW; i++) if (h[i] != lvl) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) begin
         m_mode = M_HALT; m_en = 1'b0; m_count = '0; m_tick_prev = 1'b1;
         m_run_deb = 1'b1; m_step_deb = 1'b1; m_run_press = 1'b0; m_step_press = 1'b0;
         run_hist = '1; step_hist = '1;
      end else begin
         m_te = tick_in && !m_tick_prev;
         m_tick_prev = tick_in;
         m_en = 1'b0;
         if (m_mode == M_HALT) begin
            if (m_run_press)       m_mode = M_RUN;
            else if (m_step_press) m_mode = M_STEP;
         end else if (m_mode == M_STEP) begin
            if (m_run_press)  m_mode = M_RUN;
            else if (m_te) begin m_en = 1'b1; m_mode = M_HALT; end
         end else begin
            if (cpu_halt || m_run_press) m_mode = M_HALT;
            else if (m_te)               m_en = 1'b1;
         end
         if (m_en) m_count = m_count + 1;
         run_hist  = {run_hist[HW-2:0], run_btn};
         step_hist = {step_hist[HW-2:0], step_btn};
         m_run_press  = 1'b0;
         m_step_press = 1'b0;
         if (settled(run_hist, !m_run_deb)) begin
            m_run_deb = !m_run_deb;
            m_run_press = !m_run_deb;
         end
         if (settled(step_hist, !m_step_deb)) begin
            m_step_deb = !m_step_deb;
            m_step_press = !m_step_deb;
         end
      end
   end

   // ---------------- scoreboard / monitor ----------------
   int en_seen   = 0;
   int run_rises = 0;
   bit run_prev  = 1'b0;
   int cyc       = 0;
   int last_en   = -1;

   always @(posedge clk) begin
      #2;
      cyc++;
      check_eq("cpu_en", cpu_en, m_en);
      check_eq("running", running, (m_mode == M_RUN));
      check_eq("cycle_count", cycle_count, m_count);
      if (cpu_en) begin
         en_seen++;
         if (last_en >= 0) check_eq("strobe_gap_ge_10", (cyc - last_en) >= 10, 1);
         last_en = cyc;
      end
      if (running && !run_prev) run_rises++;
      run_prev = running;
   end

   // ---------------- driver tasks ----------------
   task automatic wait_negs(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_tick_rise(input string tag);
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (tick_ph == 0 && !tick_hold) return;
      end
      check_eq(tag, 0, 1);
   endtask

   task automatic wait_strobes(input int target, input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (en_seen >= target) return;
      end
      check_eq(tag, en_seen, target);
   endtask

   task automatic set_btn(input int which, input logic v);
      if (which == 0) run_btn = v;
      else            step_btn = v;
   endtask

   task automatic press_btn(input int which, input int hold);
      @(negedge clk);
      set_btn(which, 1'b0);
      wait_negs(hold);
      set_btn(which, 1'b1);
   endtask

   task automatic bounce_btn(input int which, input int toggles);
      for (int i = 0; i < toggles; i++) begin
         @(negedge clk);
         set_btn(which, 1'b0);
         wait_negs(2);
         set_btn(which, 1'b1);
         wait_negs(1);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random stimulus ----------------
   int e0;
   int c0;
   int r0;

   initial begin
      #1 rst_btn = 1'b0;
      wait_negs(3);

      // 1: reset release with tick high, no buttons
      while (tick_ph != 2) @(negedge clk);
      rst_btn = 1'b1;
      wait_negs(100);
      check_eq("t1_en_seen", en_seen, 0);
      check_eq("t1_running", running, 0);
      check_eq("t1_count", cycle_count, 0);
      check_eq("t1_state_halt", state_dbg, 0);

      // 2: run press latency and steady strobes
      @(negedge clk);
      run_btn = 1'b0;
      repeat (6) @(posedge clk);
      #3 check_eq("t2_running_at_6", running, 0);
      @(posedge clk);
      #3 check_eq("t2_running_at_7", running, 1);
      wait_negs(4);
      run_btn = 1'b1;
      wait_strobes(5, 80, "t2_strobe_timeout");
      check_eq("t2_count_after_5", cycle_count, 5);
      check_eq("t2_en_high", cpu_en, 1);

      // 3: cpu_halt coincident with tick edge
      wait_tick_rise("t3_tick_timeout");
      cpu_halt = 1'b1;
      e0 = en_seen;
      c0 = cycle_count;
      @(negedge clk);
      cpu_halt = 1'b0;
      check_eq("t3_running_cleared", running, 0);
      wait_negs(30);
      check_eq("t3_no_strobe", en_seen, e0);
      check_eq("t3_count_frozen", cycle_count, c0);

      // 4: single step, with a second step press while pending
      tick_hold = 1'b1;
      wait_negs(2);
      e0 = en_seen;
      c0 = cycle_count;
      press_btn(1, 4);
      wait_negs(12);
      check_eq("t4_state_step", state_dbg, 1);
      press_btn(1, 4);
      wait_negs(12);
      check_eq("t4_still_step", state_dbg, 1);
      check_eq("t4_no_early_strobe", en_seen, e0);
      tick_hold = 1'b0;
      wait_negs(25);
      check_eq("t4_one_strobe", en_seen, e0 + 1);
      check_eq("t4_count_plus1", cycle_count, c0 + 1);
      check_eq("t4_back_to_halt", state_dbg, 0);

      // 5: bouncy run button then a clean hold
      r0 = run_rises;
      bounce_btn(0, 5);
      press_btn(0, 10);
      wait_negs(15);
      check_eq("t5_single_run_entry", run_rises, r0 + 1);
      check_eq("t5_running", running, 1);

      // 6: async reset between a tick edge and its strobe, then counter wrap
      wait_tick_rise("t6_tick_timeout");
      check_eq("t6_pre_running", running, 1);
      check_eq("t6_pre_count_nonzero", cycle_count != 0, 1);
      rst_btn = 1'b0;
      #1;
      check_eq("t6_rst_en", cpu_en, 0);
      check_eq("t6_rst_running", running, 0);
      check_eq("t6_rst_count", cycle_count, 0);
      wait_negs(3);
      rst_btn = 1'b1;
      press_btn(0, 6);
      wait_negs(10);
      check_eq("t6_rerun", running, 1);
      @(negedge clk);
      force dut.cycle_count = '1;
      m_count = '1;
      #1 release dut.cycle_count;
      e0 = en_seen;
      wait_strobes(e0 + 1, 30, "t6_wrap_timeout");
      check_eq("t6_wrap_to_zero", cycle_count, 0);

      // random traffic against the model
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 4))
            0: press_btn(0, $urandom_range(2, 12));
            1: press_btn(1, $urandom_range(2, 12));
            2: begin
               @(negedge clk);
               cpu_halt = 1'b1;
               @(negedge clk);
               cpu_halt = 1'b0;
            end
            3: bounce_btn($urandom_range(0, 1), $urandom_range(1, 6));
            default: ;
         endcase
         wait_negs($urandom_range(1, 25));
      end
      wait_negs(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
